// File: rtl/char_buffer_mmio_if.sv
// CPU data-bus port of the character buffer: byte address, write strobe and data,
// with read data returned combinationally from the addressed location.
interface char_buffer_mmio_if;
  logic        we;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output address, output wdata, input rdata);
  modport slave  (input we, input address, input wdata, output rdata);
endinterface

// File: rtl/char_buffer_mmio.sv
// Memory-mapped character buffer for the VGA text renderer, with synchronised
// switch levels, sticky rising-edge flags and a hardware fill engine.
//
// state       | meaning
// ST_RST_HOLD | in reset or just released; next edge starts the auto-fill
// ST_IDLE     | CPU owns the array; CTRL start accepted
// ST_FILL     | engine writes fill_value to fill_idx each cycle; CPU writes dropped
module char_buffer_mmio #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned NSW       = 7,
  parameter logic [31:0] CHAR_BASE = 32'h0000_0100,
  parameter logic [31:0] SW_ADDR   = 32'h0000_0000,
  parameter logic [31:0] EDGE_ADDR = 32'h0000_0004,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0008,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                     clk,
  input  logic                     reset,
  char_buffer_mmio_if.slave        bus,
  input  logic [NSW-1:0]           sw,
  input  logic [$clog2(DEPTH)-1:0] vid_addr,
  output logic [7:0]               vid_data,
  output logic                     busy
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] CHAR_END = {1'b0, CHAR_BASE} + 33'(DEPTH);

  typedef enum logic [1:0] {ST_RST_HOLD, ST_IDLE, ST_FILL} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   fill_idx_q, fill_idx_d;
  logic [7:0]      fill_value_q, fill_value_d;
  logic [NSW-1:0]  sw_meta_q, sw_meta_d;
  logic [NSW-1:0]  sw_sync_q, sw_sync_d;
  logic [NSW-1:0]  sw_prev_q, sw_prev_d;
  logic [NSW-1:0]  edge_q, edge_d;
  logic [7:0]      vid_data_q, vid_data_d;
  logic [7:0]      mem_q [DEPTH];

  logic            char_hit, sw_hit, edge_hit, ctrl_hit;
  logic [31:0]     char_off;
  logic [AW-1:0]   char_idx;
  logic [NSW-1:0]  edge_clr;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;
  logic            unused_bits;

  assign char_hit = (bus.address >= CHAR_BASE) && ({1'b0, bus.address} < CHAR_END);
  assign sw_hit   = (bus.address == SW_ADDR);
  assign edge_hit = (bus.address == EDGE_ADDR);
  assign ctrl_hit = (bus.address == CTRL_ADDR);
  assign char_off = bus.address - CHAR_BASE;
  assign char_idx = char_off[AW-1:0];

  assign unused_bits = ^{bus.wdata[31:16], char_off[31:AW]};

  always_comb begin
    state_d      = state_q;
    fill_idx_d   = fill_idx_q;
    fill_value_d = fill_value_q;
    mem_we       = 1'b0;
    mem_waddr    = char_idx;
    mem_wdata    = bus.wdata[7:0];
    busy         = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        state_d      = ST_FILL;
        fill_idx_d   = '0;
        fill_value_d = FILL_CHAR;
      end
      ST_IDLE: begin
        mem_we = bus.we && char_hit;
        if (bus.we && ctrl_hit && bus.wdata[0]) begin
          state_d      = ST_FILL;
          fill_idx_d   = '0;
          fill_value_d = bus.wdata[15:8];
        end
      end
      ST_FILL: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = fill_idx_q;
        mem_wdata = fill_value_q;
        // Index parks at DEPTH-1 on exit rather than wrapping.
        if (fill_idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          fill_idx_d = fill_idx_q + AW'(1);
        end
      end
      default: state_d = ST_RST_HOLD;
    endcase
  end

  always_comb begin
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    sw_prev_d  = sw_sync_q;
    edge_clr   = (bus.we && edge_hit) ? bus.wdata[NSW-1:0] : '0;
    // A new edge in the same cycle as a clear keeps the flag set.
    edge_d     = (edge_q & ~edge_clr) | (sw_sync_q & ~sw_prev_q);
    vid_data_d = mem_q[vid_addr];
  end

  always_comb begin
    bus.rdata = '0;
    if (char_hit) begin
      bus.rdata = {24'b0, mem_q[char_idx]};
    end else if (sw_hit) begin
      bus.rdata = 32'(sw_sync_q);
    end else if (edge_hit) begin
      bus.rdata = 32'(edge_q);
    end else if (ctrl_hit) begin
      bus.rdata = {16'b0, fill_value_q, 7'b0, busy};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RST_HOLD;
      fill_idx_q   <= '0;
      fill_value_q <= FILL_CHAR;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      sw_prev_q    <= '0;
      edge_q       <= '0;
      vid_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      fill_idx_q   <= fill_idx_d;
      fill_value_q <= fill_value_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      sw_prev_q    <= sw_prev_d;
      edge_q       <= edge_d;
      vid_data_q   <= vid_data_d;
    end
  end

  // Array contents are deliberately not reset; the auto-fill defines them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign vid_data = vid_data_q;
endmodule
